// File: rtl/sdfm_fifo.sv
// Per-channel FWFT result buffer behind the sigma-delta data filter.
// Captures each filter result on its update strobe and offers level, sticky flags and a threshold IRQ.
module sdfm_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              SYSCLK,
  input  logic              SYSRST,
  input  logic              fifo_en,
  input  logic [DATA_W-1:0] filt_data_out,
  input  logic              filt_data_update,
  input  logic              rd_pop,
  input  logic [PTR_W:0]    thr_level,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    level,
  output logic              empty,
  output logic              full,
  output logic              ovf_flag,
  output logic              udf_flag,
  output logic              irq_thr
);

  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             irq_q, irq_d;
  logic             push, pop_ok, empty_c, full_c;

  always_comb begin
    empty_c  = (level_q == '0);
    full_c   = (level_q == DEPTH_L);
    pop_ok   = rd_pop & fifo_en & ~empty_c;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    push     = filt_data_update & fifo_en & (~full_c | pop_ok);

    wr_ptr_d = push   ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop_ok) level_d = level_q + (PTR_W+1)'(1);
    if (!push && pop_ok) level_d = level_q - (PTR_W+1)'(1);
    if (!fifo_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    // Set takes priority over a coincident clear.
    ovf_d = (ovf_q & ~clr_flags) | (filt_data_update & fifo_en & full_c & ~pop_ok);
    udf_d = (udf_q & ~clr_flags) | (rd_pop & fifo_en & empty_c);
    irq_d = fifo_en & (thr_level != '0) & (level_d >= thr_level);
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (push && !SYSRST) mem[wr_ptr_q] <= filt_data_out;
  end

  always_comb begin
    rd_data  = empty_c ? '0 : mem[rd_ptr_q];
    level    = level_q;
    empty    = empty_c;
    full     = full_c;
    ovf_flag = ovf_q;
    udf_flag = udf_q;
    irq_thr  = irq_q;
  end

endmodule

// File: tb/tb_sdfm_fifo.sv
// Randomized scoreboard bench for sdfm_fifo: a queue-based model predicts each cycle's outputs,
// a monitor compares them just after every rising edge.
module tb_sdfm_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_en = 1'b0;
  logic [31:0] filt_data_out = '0;
  logic        filt_data_update = 1'b0;
  logic        rd_pop = 1'b0;
  logic [4:0]  thr_level = '0;
  logic        clr_flags = 1'b0;
  logic [31:0] rd_data;
  logic [4:0]  level;
  logic        empty, full, ovf_flag, udf_flag, irq_thr;

  sdfm_fifo dut (
    .SYSCLK(clk), .SYSRST(rst), .fifo_en(fifo_en),
    .filt_data_out(filt_data_out), .filt_data_update(filt_data_update),
    .rd_pop(rd_pop), .thr_level(thr_level), .clr_flags(clr_flags),
    .rd_data(rd_data), .level(level), .empty(empty), .full(full),
    .ovf_flag(ovf_flag), .udf_flag(udf_flag), .irq_thr(irq_thr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [4:0]  lvl;
    logic        emp, ful, ovf, udf, irq;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0, m_udf = 1'b0, m_irq = 1'b0;
  logic [4:0]  thr = '0;
  int          chk_cnt = 0, pass_cnt = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL cyc=%0d %s got=%h want=%h", cyc, name, got, want);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_data", rd_data, e.rd);
      check("level", 32'(level), 32'(e.lvl));
      check("empty", 32'(empty), 32'(e.emp));
      check("full", 32'(full), 32'(e.ful));
      check("ovf_flag", 32'(ovf_flag), 32'(e.ovf));
      check("udf_flag", 32'(udf_flag), 32'(e.udf));
      check("irq_thr", 32'(irq_thr), 32'(e.irq));
    end
  end

  // One clock of stimulus; the model is advanced and its prediction queued for the monitor.
  task automatic step(input logic upd, input logic [31:0] d, input logic pop,
                      input logic clr, input logic en, input logic r);
    bit do_pop, do_push;
    exp_t x;
    @(negedge clk);
    rst = r; fifo_en = en; filt_data_update = upd; filt_data_out = d;
    rd_pop = pop; clr_flags = clr; thr_level = thr;
    if (r) begin
      mq.delete(); m_ovf = 0; m_udf = 0; m_irq = 0;
    end else if (!en) begin
      mq.delete(); m_irq = 0;
      if (clr) begin m_ovf = 0; m_udf = 0; end
    end else begin
      do_pop  = pop && mq.size() > 0;
      do_push = upd && (mq.size() < 16 || do_pop);
      m_ovf = (m_ovf && !clr) || (upd && mq.size() == 16 && !do_pop);
      m_udf = (m_udf && !clr) || (pop && mq.size() == 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d);
      m_irq = (thr != 0) && (mq.size() >= int'(thr));
    end
    x.rd  = (mq.size() == 0) ? 32'h0 : mq[0];
    x.lvl = 5'(mq.size());
    x.emp = (mq.size() == 0);
    x.ful = (mq.size() == 16);
    x.ovf = m_ovf; x.udf = m_udf; x.irq = m_irq;
    exp_q.push_back(x);
  endtask

  task automatic push_w(input logic [31:0] d); step(1, d, 0, 0, 1, 0); endtask
  task automatic pop_w();                      step(0, 0, 1, 0, 1, 0); endtask
  task automatic idle();                       step(0, 0, 0, 0, 1, 0); endtask

  initial begin
    // Reset and ordered three-word transfer
    step(0, 0, 0, 0, 1, 1);
    step(1, 32'hDEADBEEF, 1, 0, 1, 1);
    push_w(32'h11111111); push_w(32'h22222222); push_w(32'h33333333);
    pop_w(); pop_w(); pop_w(); idle();

    // Overflow: 17 pushes, then clear
    for (int i = 1; i <= 17; i++) push_w(32'hA000_0000 + 32'(i));
    idle();
    step(0, 0, 0, 1, 1, 0);

    // Full with simultaneous push and pop
    step(1, 32'hBEEF0001, 1, 0, 1, 0);
    step(1, 32'hBEEF0002, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++) pop_w();

    // Empty pop without and with push
    pop_w(); idle();
    step(0, 0, 0, 1, 1, 0);
    step(1, 32'hC0DE0001, 1, 0, 1, 0);
    pop_w(); step(0, 0, 0, 1, 1, 0);

    // Threshold interrupt
    thr = 5'd4;
    for (int i = 0; i < 4; i++) push_w(32'h4400_0000 + 32'(i));
    idle(); pop_w(); idle();
    thr = 5'd0;
    for (int i = 0; i < 5; i++) push_w(32'h5500_0000 + 32'(i));
    thr = 5'd20; push_w(32'h55AA55AA); idle();
    thr = 5'd0;
    for (int i = 0; i < 10; i++) pop_w();

    // Interleaved push/pop across pointer wrap, then a one-cycle disable
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 45), 0, 1, 0);
    push_w(32'hFFFF0000); push_w(32'hFFFF0001);
    pop_w(); idle();  // leaves udf possibly set; flags must survive the disable
    step(1, 32'h12345678, 1, 0, 0, 0);
    idle();

    // Longer randomized soak with random threshold, clears, disables and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) thr = 5'($urandom_range(0, 18));
      step(($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0),
           ($urandom_range(0, 149) == 0));
    end
    idle();

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
